qpu_exu_disp_sb: RTL and testbench

Parametrised QPU dispatch stage with an integrated scoreboard. It sits between decode and the functional units and holds each instruction until its RAW, WAW and qubit-flag hazards clear. It tracks outstanding long-pipe writes in an internal OITF and outstanding measurements in an internal MOITF. Accepted instructions are routed to one of `NUM_CH` execution channels through a registered output stage.

---
 rtl/qpu_exu_disp_sb.sv | 203 ++++++++++++++++++++
 tb/tb_qpu_exu_disp_sb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_exu_disp_sb.sv
// QPU dispatch stage with OITF/MOITF scoreboard and a registered output stage.
// Define QPU_DISP_RET_BYPASS_EN to let a same-cycle retire unblock dispatch.
module qpu_exu_disp_sb #(
  parameter int XLEN        = 32,
  parameter int RFIDX_W     = 5,
  parameter int INFO_W      = 32,
  parameter int PC_W        = 32,
  parameter int TIME_W      = 16,
  parameter int QUBIT_NUM   = 8,
  parameter int NUM_CH      = 2,
  parameter int OITF_DEPTH  = 4,
  parameter int MOITF_DEPTH = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int ITAG_W     = $clog2(OITF_DEPTH),
  localparam int MAW        = $clog2(MOITF_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 disp_i_valid,
  output logic                 disp_i_ready,
  input  logic [CH_W-1:0]      disp_i_ch,
  input  logic                 disp_i_longp,
  input  logic                 disp_i_rs1en,
  input  logic                 disp_i_rs2en,
  input  logic                 disp_i_rs1x0,
  input  logic                 disp_i_rs2x0,
  input  logic                 disp_i_rdwen,
  input  logic [RFIDX_W-1:0]   disp_i_rs1idx,
  input  logic [RFIDX_W-1:0]   disp_i_rs2idx,
  input  logic [RFIDX_W-1:0]   disp_i_rdidx,
  input  logic [XLEN-1:0]      disp_i_rs1,
  input  logic [XLEN-1:0]      disp_i_rs2,
  input  logic [XLEN-1:0]      disp_i_imm,
  input  logic [INFO_W-1:0]    disp_i_info,
  input  logic [PC_W-1:0]      disp_i_pc,
  input  logic                 disp_i_ntp,
  input  logic                 disp_i_fmr,
  input  logic                 disp_i_measure,
  input  logic                 disp_i_nqf,
  input  logic [TIME_W-1:0]    disp_i_clk,
  input  logic [QUBIT_NUM-1:0] disp_i_qmr,
  output logic                 disp_o_valid,
  input  logic                 disp_o_ready,
  output logic [CH_W-1:0]      disp_o_ch,
  output logic [ITAG_W-1:0]    disp_o_itag,
  output logic [XLEN-1:0]      disp_o_rs1,
  output logic [XLEN-1:0]      disp_o_rs2,
  output logic [XLEN-1:0]      disp_o_imm,
  output logic                 disp_o_rdwen,
  output logic [RFIDX_W-1:0]   disp_o_rdidx,
  output logic [INFO_W-1:0]    disp_o_info,
  output logic [PC_W-1:0]      disp_o_pc,
  output logic [TIME_W-1:0]    disp_o_clk,
  output logic [QUBIT_NUM-1:0] disp_o_qmr,
  output logic                 disp_o_ntp,
  output logic                 disp_o_fmr,
  output logic                 disp_o_measure,
  input  logic                 oitf_ret_ena,
  input  logic                 moitf_ret_ena,
  output logic                 oitf_empty,
  output logic                 oitf_err
);

  localparam logic [ITAG_W-1:0] OITF_PTR_ONE  = ITAG_W'(1);
  localparam logic [MAW-1:0]    MOITF_PTR_ONE = MAW'(1);

  logic [OITF_DEPTH-1:0] oitf_rdwen_r;
  logic [RFIDX_W-1:0]    oitf_rdidx_r [OITF_DEPTH];
  logic [ITAG_W-1:0]     oitf_wptr_r, oitf_rptr_r;
  logic [ITAG_W:0]       oitf_cnt_r;
  logic [QUBIT_NUM-1:0]  moitf_q_r [MOITF_DEPTH];
  logic [MAW-1:0]        moitf_wptr_r, moitf_rptr_r;
  logic [MAW:0]          moitf_cnt_r;
  logic                  oitf_err_r;

  logic [OITF_DEPTH-1:0]  oitf_vld_s;
  logic [MOITF_DEPTH-1:0] moitf_vld_s;
  logic [QUBIT_NUM-1:0]   mq_or_s;
  logic oitf_ret_s, moitf_ret_s, oitf_full_s, moitf_full_s;
  logic raw_s, waw_s, qhaz_s, cond_s, acc_s, oitf_push_s, moitf_push_s;

  // A retire is only honoured when the tracker holds something
  assign oitf_ret_s  = oitf_ret_ena & (|oitf_cnt_r);
  assign moitf_ret_s = moitf_ret_ena & (|moitf_cnt_r);

  // Hazard and capacity evaluation against the start-of-cycle tracker state
  always_comb begin
    oitf_vld_s  = {OITF_DEPTH{1'b0}};
    moitf_vld_s = {MOITF_DEPTH{1'b0}};
    raw_s       = 1'b0;
    waw_s       = 1'b0;
    mq_or_s     = {QUBIT_NUM{1'b0}};
    for (int i = 0; i < OITF_DEPTH; i++) begin
      oitf_vld_s[i] = ({1'b0, ITAG_W'(i) - oitf_rptr_r} < oitf_cnt_r);
    end
    for (int j = 0; j < MOITF_DEPTH; j++) begin
      moitf_vld_s[j] = ({1'b0, MAW'(j) - moitf_rptr_r} < moitf_cnt_r);
    end
`ifdef QPU_DISP_RET_BYPASS_EN
    oitf_vld_s[oitf_rptr_r]   = oitf_vld_s[oitf_rptr_r] & ~oitf_ret_s;
    moitf_vld_s[moitf_rptr_r] = moitf_vld_s[moitf_rptr_r] & ~moitf_ret_s;
    oitf_full_s  = oitf_cnt_r[ITAG_W] & ~oitf_ret_s;
    moitf_full_s = moitf_cnt_r[MAW] & ~moitf_ret_s;
`else
    oitf_full_s  = oitf_cnt_r[ITAG_W];
    moitf_full_s = moitf_cnt_r[MAW];
`endif
    for (int i = 0; i < OITF_DEPTH; i++) begin
      raw_s = raw_s | (oitf_vld_s[i] & oitf_rdwen_r[i] &
              ((disp_i_rs1en & (oitf_rdidx_r[i] == disp_i_rs1idx)) |
               (disp_i_rs2en & (oitf_rdidx_r[i] == disp_i_rs2idx))));
      waw_s = waw_s | (oitf_vld_s[i] & oitf_rdwen_r[i] & disp_i_rdwen &
              (oitf_rdidx_r[i] == disp_i_rdidx));
    end
    for (int j = 0; j < MOITF_DEPTH; j++) begin
      mq_or_s = mq_or_s | (moitf_q_r[j] & {QUBIT_NUM{moitf_vld_s[j]}});
    end
    qhaz_s = disp_i_nqf & (|(disp_i_rs1[QUBIT_NUM-1:0] & mq_or_s));
    cond_s = ~raw_s & ~waw_s & ~qhaz_s & ~(disp_i_longp & oitf_full_s) &
             ~(disp_i_measure & moitf_full_s);
  end

  assign disp_i_ready = cond_s & (~disp_o_valid | disp_o_ready);
  assign acc_s        = disp_i_valid & disp_i_ready;
  assign oitf_push_s  = acc_s & disp_i_longp;
  assign moitf_push_s = acc_s & disp_i_measure;
  assign oitf_empty   = ~(|oitf_cnt_r);
  assign oitf_err     = oitf_err_r;

  // Tracker FIFOs: push on accept, pop on retire, sticky error on empty retire
  always_ff @(posedge clk) begin
    if (rst) begin
      oitf_rdwen_r <= {OITF_DEPTH{1'b0}};
      for (int i = 0; i < OITF_DEPTH; i++) oitf_rdidx_r[i] <= {RFIDX_W{1'b0}};
      for (int j = 0; j < MOITF_DEPTH; j++) moitf_q_r[j] <= {QUBIT_NUM{1'b0}};
      oitf_wptr_r  <= {ITAG_W{1'b0}};
      oitf_rptr_r  <= {ITAG_W{1'b0}};
      oitf_cnt_r   <= {(ITAG_W+1){1'b0}};
      moitf_wptr_r <= {MAW{1'b0}};
      moitf_rptr_r <= {MAW{1'b0}};
      moitf_cnt_r  <= {(MAW+1){1'b0}};
      oitf_err_r   <= 1'b0;
    end else begin
      if (oitf_push_s) begin
        oitf_rdwen_r[oitf_wptr_r] <= disp_i_rdwen;
        oitf_rdidx_r[oitf_wptr_r] <= disp_i_rdidx;
        oitf_wptr_r <= oitf_wptr_r + OITF_PTR_ONE;
      end
      if (oitf_ret_s) oitf_rptr_r <= oitf_rptr_r + OITF_PTR_ONE;
      oitf_cnt_r <= oitf_cnt_r + {{ITAG_W{1'b0}}, oitf_push_s}
                               - {{ITAG_W{1'b0}}, oitf_ret_s};
      if (moitf_push_s) begin
        moitf_q_r[moitf_wptr_r] <= disp_i_rs1[QUBIT_NUM-1:0];
        moitf_wptr_r <= moitf_wptr_r + MOITF_PTR_ONE;
      end
      if (moitf_ret_s) moitf_rptr_r <= moitf_rptr_r + MOITF_PTR_ONE;
      moitf_cnt_r <= moitf_cnt_r + {{MAW{1'b0}}, moitf_push_s}
                                 - {{MAW{1'b0}}, moitf_ret_s};
      oitf_err_r <= oitf_err_r | (oitf_ret_ena & ~(|oitf_cnt_r)) |
                    (moitf_ret_ena & ~(|moitf_cnt_r));
    end
  end

  // Output stage: loads on accept, holds while stalled, drops valid once taken
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_o_valid   <= 1'b0;
      disp_o_ch      <= {CH_W{1'b0}};
      disp_o_itag    <= {ITAG_W{1'b0}};
      disp_o_rs1     <= {XLEN{1'b0}};
      disp_o_rs2     <= {XLEN{1'b0}};
      disp_o_imm     <= {XLEN{1'b0}};
      disp_o_rdwen   <= 1'b0;
      disp_o_rdidx   <= {RFIDX_W{1'b0}};
      disp_o_info    <= {INFO_W{1'b0}};
      disp_o_pc      <= {PC_W{1'b0}};
      disp_o_clk     <= {TIME_W{1'b0}};
      disp_o_qmr     <= {QUBIT_NUM{1'b0}};
      disp_o_ntp     <= 1'b0;
      disp_o_fmr     <= 1'b0;
      disp_o_measure <= 1'b0;
    end else if (acc_s) begin
      disp_o_valid   <= 1'b1;
      disp_o_ch      <= disp_i_ch;
      disp_o_itag    <= disp_i_longp ? oitf_wptr_r : {ITAG_W{1'b0}};
      disp_o_rs1     <= disp_i_rs1 & {XLEN{~disp_i_rs1x0}};
      disp_o_rs2     <= disp_i_rs2 & {XLEN{~disp_i_rs2x0}};
      disp_o_imm     <= disp_i_imm;
      disp_o_rdwen   <= disp_i_rdwen;
      disp_o_rdidx   <= disp_i_rdidx;
      disp_o_info    <= disp_i_info;
      disp_o_pc      <= disp_i_pc;
      disp_o_clk     <= disp_i_clk & {TIME_W{disp_i_ntp}};
      disp_o_qmr     <= disp_i_qmr & {QUBIT_NUM{disp_i_fmr}};
      disp_o_ntp     <= disp_i_ntp;
      disp_o_fmr     <= disp_i_fmr;
      disp_o_measure <= disp_i_measure;
    end else if (disp_o_ready) begin
      disp_o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qpu_exu_disp_sb.sv
// Self-checking bench for qpu_exu_disp_sb: masking vector table, scoreboard on the
// output handshake, and hand-written hazard / backpressure / reset sequences.
module tb_qpu_exu_disp_sb;

`ifdef QPU_DISP_RET_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic disp_i_valid = 1'b0, disp_i_ready;
  logic [0:0] disp_i_ch;
  logic disp_i_longp, disp_i_rs1en, disp_i_rs2en, disp_i_rs1x0, disp_i_rs2x0, disp_i_rdwen;
  logic [4:0] disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx;
  logic [31:0] disp_i_rs1, disp_i_rs2, disp_i_imm, disp_i_info, disp_i_pc;
  logic disp_i_ntp, disp_i_fmr, disp_i_measure, disp_i_nqf;
  logic [15:0] disp_i_clk;
  logic [7:0] disp_i_qmr;
  logic disp_o_valid, disp_o_ready = 1'b1;
  logic [0:0] disp_o_ch;
  logic [1:0] disp_o_itag;
  logic [31:0] disp_o_rs1, disp_o_rs2, disp_o_imm, disp_o_info, disp_o_pc;
  logic disp_o_rdwen;
  logic [4:0] disp_o_rdidx;
  logic [15:0] disp_o_clk;
  logic [7:0] disp_o_qmr;
  logic disp_o_ntp, disp_o_fmr, disp_o_measure;
  logic oitf_ret_ena = 1'b0, moitf_ret_ena = 1'b0, oitf_empty, oitf_err;

  int n_pass = 0, n_total = 0;

  qpu_exu_disp_sb dut (
    .clk(clk), .rst(rst), .disp_i_valid(disp_i_valid), .disp_i_ready(disp_i_ready),
    .disp_i_ch(disp_i_ch), .disp_i_longp(disp_i_longp), .disp_i_rs1en(disp_i_rs1en),
    .disp_i_rs2en(disp_i_rs2en), .disp_i_rs1x0(disp_i_rs1x0), .disp_i_rs2x0(disp_i_rs2x0),
    .disp_i_rdwen(disp_i_rdwen), .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx),
    .disp_i_rdidx(disp_i_rdidx), .disp_i_rs1(disp_i_rs1), .disp_i_rs2(disp_i_rs2),
    .disp_i_imm(disp_i_imm), .disp_i_info(disp_i_info), .disp_i_pc(disp_i_pc),
    .disp_i_ntp(disp_i_ntp), .disp_i_fmr(disp_i_fmr), .disp_i_measure(disp_i_measure),
    .disp_i_nqf(disp_i_nqf), .disp_i_clk(disp_i_clk), .disp_i_qmr(disp_i_qmr),
    .disp_o_valid(disp_o_valid), .disp_o_ready(disp_o_ready), .disp_o_ch(disp_o_ch),
    .disp_o_itag(disp_o_itag), .disp_o_rs1(disp_o_rs1), .disp_o_rs2(disp_o_rs2),
    .disp_o_imm(disp_o_imm), .disp_o_rdwen(disp_o_rdwen), .disp_o_rdidx(disp_o_rdidx),
    .disp_o_info(disp_o_info), .disp_o_pc(disp_o_pc), .disp_o_clk(disp_o_clk),
    .disp_o_qmr(disp_o_qmr), .disp_o_ntp(disp_o_ntp), .disp_o_fmr(disp_o_fmr),
    .disp_o_measure(disp_o_measure), .oitf_ret_ena(oitf_ret_ena),
    .moitf_ret_ena(moitf_ret_ena), .oitf_empty(oitf_empty), .oitf_err(oitf_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         longp;
    logic [1:0]   itag;
    logic [159:0] data;
    logic [33:0]  ctl;
  } exp_t;

  typedef struct packed {
    logic [31:0] rs1; logic rs1x0; logic [31:0] rs2; logic rs2x0;
    logic ntp; logic [15:0] tclk; logic fmr; logic [7:0] qmr;
    logic [31:0] e_rs1; logic [31:0] e_rs2; logic [15:0] e_clk; logic [7:0] e_qmr;
  } vec_t;

  exp_t sbq[$];
  logic [1:0] mdl_wptr = 2'd0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard: predict on accepted input, compare when the output is consumed
  always @(negedge clk) begin : sb
    exp_t e;
    if (rst) begin
      sbq.delete();
      mdl_wptr = 2'd0;
    end else begin
      if (disp_o_valid && disp_o_ready) begin
        if (sbq.size() == 0) chk("sb_spurious", disp_o_valid, 1'b0);
        else begin
          e = sbq.pop_front();
          chk("sb_data", {disp_o_rs1, disp_o_rs2, disp_o_imm, disp_o_pc, disp_o_info}, e.data);
          chk("sb_ctl", {disp_o_ch, disp_o_rdwen, disp_o_rdidx, disp_o_clk, disp_o_qmr,
                         disp_o_ntp, disp_o_fmr, disp_o_measure}, e.ctl);
          if (e.longp) chk("sb_itag", disp_o_itag, e.itag);
        end
      end
      if (disp_i_valid && disp_i_ready) begin
        e.longp = disp_i_longp;
        e.itag  = mdl_wptr;
        e.data  = {(disp_i_rs1x0 ? 32'd0 : disp_i_rs1), (disp_i_rs2x0 ? 32'd0 : disp_i_rs2),
                   disp_i_imm, disp_i_pc, disp_i_info};
        e.ctl   = {disp_i_ch, disp_i_rdwen, disp_i_rdidx, (disp_i_ntp ? disp_i_clk : 16'd0),
                   (disp_i_fmr ? disp_i_qmr : 8'd0), disp_i_ntp, disp_i_fmr, disp_i_measure};
        if (disp_i_longp) mdl_wptr = mdl_wptr + 2'd1;
        sbq.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Hazard controls off, payload randomised
  task automatic clr_in();
    disp_i_valid = 1'b0; disp_i_longp = 1'b0; disp_i_rs1en = 1'b0; disp_i_rs2en = 1'b0;
    disp_i_rdwen = 1'b0; disp_i_measure = 1'b0; disp_i_nqf = 1'b0;
    disp_i_ch = 1'($urandom); disp_i_rs1x0 = 1'($urandom); disp_i_rs2x0 = 1'($urandom);
    disp_i_rs1idx = 5'($urandom); disp_i_rs2idx = 5'($urandom); disp_i_rdidx = 5'($urandom);
    disp_i_rs1 = $urandom; disp_i_rs2 = $urandom; disp_i_imm = $urandom;
    disp_i_info = $urandom; disp_i_pc = $urandom; disp_i_ntp = 1'($urandom);
    disp_i_fmr = 1'($urandom); disp_i_clk = 16'($urandom); disp_i_qmr = 8'($urandom);
  endtask

  // Hold valid until accepted, at most maxc stalled cycles
  task automatic wait_acc(input int maxc, input string nm);
    int cyc = 0;
    disp_i_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (disp_i_ready) break;
      if (cyc >= maxc) begin
        chk(nm, disp_i_ready, 1'b1);
        break;
      end
      cyc++;
    end
    tick();
    disp_i_valid = 1'b0;
  endtask

  vec_t vt[4];
  logic [31:0] pc_a;

  initial begin
    vt[0] = '{32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 16'h1234, 1'b1, 8'hA5,
              32'h0, 32'h1234_5678, 16'h0, 8'hA5};
    vt[1] = '{32'hFFFF_FFFF, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 16'h1234, 1'b0, 8'hA5,
              32'hFFFF_FFFF, 32'h0, 16'h1234, 8'h0};
    vt[2] = '{32'hDEAD_BEEF, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b1, 16'hFFFF, 1'b1, 8'hFF,
              32'h0, 32'h0, 16'hFFFF, 8'hFF};
    vt[3] = '{32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 16'hFFFF, 1'b0, 8'h01,
              32'h1, 32'h8000_0000, 16'h0, 8'h0};
    clr_in();
    do_rst();

    // Reset state, then sticky error on empty retire
    @(negedge clk);
    chk("rst_empty", oitf_empty, 1'b1);
    chk("rst_err", oitf_err, 1'b0);
    chk("rst_ovalid", disp_o_valid, 1'b0);
    chk("rst_ors1", disp_o_rs1, 32'h0);
    tick(); oitf_ret_ena = 1'b1; tick(); oitf_ret_ena = 1'b0;
    @(negedge clk); chk("err_set", oitf_err, 1'b1);
    tick(); tick(); tick();
    @(negedge clk); chk("err_sticky", oitf_err, 1'b1);
    tick();
    for (int k = 0; k < 2; k++) begin
      clr_in(); disp_i_longp = 1'b1; wait_acc(0, "rst_lp_acc");
    end
    @(negedge clk); chk("two_outstanding", oitf_empty, 1'b0);
    do_rst();
    @(negedge clk);
    chk("flush_empty", oitf_empty, 1'b1);
    chk("flush_err", oitf_err, 1'b0);
    chk("flush_ovalid", disp_o_valid, 1'b0);
    tick();

    // Masking vector table
    for (int v = 0; v < 4; v++) begin
      clr_in();
      disp_i_rs1 = vt[v].rs1; disp_i_rs1x0 = vt[v].rs1x0;
      disp_i_rs2 = vt[v].rs2; disp_i_rs2x0 = vt[v].rs2x0;
      disp_i_ntp = vt[v].ntp; disp_i_clk = vt[v].tclk;
      disp_i_fmr = vt[v].fmr; disp_i_qmr = vt[v].qmr;
      wait_acc(0, "vec_acc");
      @(negedge clk);
      chk("vec_rs1", disp_o_rs1, vt[v].e_rs1);
      chk("vec_rs2", disp_o_rs2, vt[v].e_rs2);
      chk("vec_clk", disp_o_clk, vt[v].e_clk);
      chk("vec_qmr", disp_o_qmr, vt[v].e_qmr);
      tick();
    end

    // RAW on x5 behind a long-pipe write
    do_rst();
    clr_in(); disp_i_longp = 1'b1; disp_i_rdwen = 1'b1; disp_i_rdidx = 5'd5;
    wait_acc(0, "raw_lp_acc");
    clr_in(); disp_i_rs1en = 1'b1; disp_i_rs1idx = 5'd5; disp_i_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); chk("raw_stall", disp_i_ready, 1'b0);
      tick();
    end
    oitf_ret_ena = 1'b1;
    @(negedge clk); chk("raw_ret_cycle", disp_i_ready, BYP);
    tick(); oitf_ret_ena = 1'b0;
    if (!BYP) begin
      @(negedge clk); chk("raw_after_ret", disp_i_ready, 1'b1);
      tick();
    end
    disp_i_valid = 1'b0;
    @(negedge clk); chk("raw_empty", oitf_empty, 1'b1);
    tick();

    // OITF full, non-long-pipe bypass of the full condition, itag wrap
    do_rst();
    for (int k = 0; k < 4; k++) begin
      clr_in(); disp_i_longp = 1'b1; disp_i_rdwen = 1'b1; disp_i_rdidx = 5'(10 + k);
      wait_acc(0, "full_lp_acc");
    end
    clr_in(); disp_i_longp = 1'b1; disp_i_rdwen = 1'b1; disp_i_rdidx = 5'd20;
    disp_i_valid = 1'b1;
    @(negedge clk); chk("full_stall", disp_i_ready, 1'b0);
    tick();
    clr_in(); disp_i_rdwen = 1'b1; disp_i_rdidx = 5'd21;
    wait_acc(0, "full_nonlp_acc");
    clr_in(); disp_i_longp = 1'b1; disp_i_rdwen = 1'b1; disp_i_rdidx = 5'd22;
    disp_i_valid = 1'b1; oitf_ret_ena = 1'b1;
    @(negedge clk); chk("full_ret_cycle", disp_i_ready, BYP);
    tick(); oitf_ret_ena = 1'b0;
    if (!BYP) begin
      @(negedge clk); chk("full_after_ret", disp_i_ready, 1'b1);
      tick();
    end
    disp_i_valid = 1'b0;

    // Qubit hazard against an outstanding measurement
    do_rst();
    clr_in(); disp_i_measure = 1'b1; disp_i_rs1 = 32'h3;
    wait_acc(0, "q_meas_acc");
    clr_in(); disp_i_fmr = 1'b1; disp_i_nqf = 1'b1; disp_i_rs1 = 32'h2; disp_i_valid = 1'b1;
    @(negedge clk); chk("q_stall", disp_i_ready, 1'b0);
    tick(); disp_i_rs1 = 32'h4;
    @(negedge clk); chk("q_disjoint", disp_i_ready, 1'b1);
    tick(); disp_i_rs1 = 32'h2;
    @(negedge clk); chk("q_stall2", disp_i_ready, 1'b0);
    tick(); moitf_ret_ena = 1'b1;
    @(negedge clk); chk("q_ret_cycle", disp_i_ready, BYP);
    tick(); moitf_ret_ena = 1'b0;
    if (!BYP) begin
      @(negedge clk); chk("q_after_ret", disp_i_ready, 1'b1);
      tick();
    end
    disp_i_valid = 1'b0;

    // Output backpressure: hold, no accept, no push
    do_rst();
    disp_o_ready = 1'b0;
    clr_in(); pc_a = disp_i_pc;
    wait_acc(0, "bp_a_acc");
    clr_in(); disp_i_longp = 1'b1; disp_i_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_pc", disp_o_pc, pc_a);
      chk("bp_ready", disp_i_ready, 1'b0);
      chk("bp_nopush", oitf_empty, 1'b1);
      tick();
    end
    disp_o_ready = 1'b1;
    @(negedge clk); chk("bp_release", disp_i_ready, 1'b1);
    tick(); disp_i_valid = 1'b0;

    repeat (3) tick();
    @(negedge clk); chk("sb_drain", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
